// File: rtl/chess_clock_pkg.sv
// Shared types for the chess clock: FSM states, BCD digit and MM:SS record.
// No logic here; the reload helper is a pure constant function.
// No flow control; consumed by the interface, decoder and top.
package chess_clock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN_A  = 3'd1,
        ST_RUN_B  = 3'd2,
        ST_PAUSED = 3'd3,
        ST_FLAG   = 3'd4
    } state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
    } mmss_t;

    function automatic mmss_t reload_value(input int unsigned start_min);
        mmss_t v;
        v.min_tens = bcd_t'(start_min / 10);
        v.min_ones = bcd_t'(start_min % 10);
        v.sec_tens = '0;
        v.sec_ones = '0;
        return v;
    endfunction

endpackage

// File: rtl/chess_clock_timer_if.sv
// Player buttons in, four display digits and status lamps out.
// Pulses are single-cycle strobes; outputs are plain levels.
// No backpressure: every strobe is consumed on the edge it is seen.
interface chess_clock_timer_if;
    import chess_clock_pkg::*;

    logic start;
    logic press_a;
    logic press_b;
    logic pause;
    bcd_t digit3;
    bcd_t digit2;
    bcd_t digit1;
    bcd_t digit0;
    logic disp_b;
    logic active_a;
    logic active_b;
    logic flag_a;
    logic flag_b;

    modport master (
        output start, press_a, press_b, pause,
        input  digit3, digit2, digit1, digit0,
        input  disp_b, active_a, active_b, flag_a, flag_b
    );

    modport slave (
        input  start, press_a, press_b, pause,
        output digit3, digit2, digit1, digit0,
        output disp_b, active_a, active_b, flag_a, flag_b
    );
endinterface

// File: rtl/chess_clock_timer_dec.sv
// One-second BCD MM:SS decrement with borrow chain; 00:00 saturates.
// Purely combinational, zero latency.
// No flow control.
module bcd_mmss_dec
    import chess_clock_pkg::*;
(
    input  mmss_t cur,
    output mmss_t dec,
    output logic  is_zero,
    output logic  is_zero_next
);

    assign is_zero      = (cur == '0);
    assign is_zero_next = !is_zero && (dec == '0);

    always_comb begin
        dec = cur;
        if (!is_zero) begin
            if (cur.sec_ones != 4'd0) begin
                dec.sec_ones = cur.sec_ones - 4'd1;
            end else begin
                dec.sec_ones = 4'd9;
                if (cur.sec_tens != 4'd0) begin
                    dec.sec_tens = cur.sec_tens - 4'd1;
                end else begin
                    dec.sec_tens = 4'd5;
                    if (cur.min_ones != 4'd0) begin
                        dec.min_ones = cur.min_ones - 4'd1;
                    end else begin
                        dec.min_ones = 4'd9;
                        dec.min_tens = cur.min_tens - 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/chess_clock_timer.sv
// Two-player chess clock: BCD countdown, hand-over, pause and flag detection.
// Outputs decode registered state combinationally; strobes act on the same edge.
// No backpressure; overlapping strobes resolve by start > flag > pause > press.
module chess_clock_timer
    import chess_clock_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned START_MIN = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    chess_clock_timer_if.slave   bus
);

    localparam int unsigned    PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam mmss_t          RELOAD     = reload_value(START_MIN);

    state_t          state_q;
    state_t          state_d;
    logic            run_b_q;
    logic [PW-1:0]   presc_q;
    mmss_t           time_a_q;
    mmss_t           time_b_q;
    logic            flag_a_q;
    logic            flag_b_q;

    logic            running;
    logic            tick;
    logic            expire;
    logic            reload;
    mmss_t           run_time;
    mmss_t           dec_time;
    logic            cur_zero;
    logic            zero_next;
    mmss_t           disp_time;

    assign running  = (state_q == ST_RUN_A) || (state_q == ST_RUN_B);
    assign tick     = running && (presc_q == PRESC_LAST);
    assign run_time = (state_q == ST_RUN_B) ? time_b_q : time_a_q;
    assign expire   = tick && zero_next;
    assign reload   = bus.start && (state_q != ST_IDLE);

    bcd_mmss_dec u_dec (
        .cur          (run_time),
        .dec          (dec_time),
        .is_zero      (cur_zero),
        .is_zero_next (zero_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A decrement that reaches 00:00 beats a same-edge pause or press.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_RUN_A;
            end
            ST_RUN_A: begin
                if (bus.start)        state_d = ST_IDLE;
                else if (expire)      state_d = ST_FLAG;
                else if (bus.pause)   state_d = ST_PAUSED;
                else if (bus.press_a) state_d = ST_RUN_B;
            end
            ST_RUN_B: begin
                if (bus.start)        state_d = ST_IDLE;
                else if (expire)      state_d = ST_FLAG;
                else if (bus.pause)   state_d = ST_PAUSED;
                else if (bus.press_b) state_d = ST_RUN_A;
            end
            ST_PAUSED: begin
                if (bus.start)      state_d = ST_IDLE;
                else if (bus.pause) state_d = run_b_q ? ST_RUN_B : ST_RUN_A;
            end
            ST_FLAG: begin
                if (bus.start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_b_q  <= 1'b0;
            time_a_q <= RELOAD;
            time_b_q <= RELOAD;
            flag_a_q <= 1'b0;
            flag_b_q <= 1'b0;
        end else if (reload) begin
            run_b_q  <= 1'b0;
            time_a_q <= RELOAD;
            time_b_q <= RELOAD;
            flag_a_q <= 1'b0;
            flag_b_q <= 1'b0;
        end else begin
            if (tick && !cur_zero) begin
                if (state_q == ST_RUN_B) time_b_q <= dec_time;
                else                     time_a_q <= dec_time;
            end
            if (expire) begin
                if (state_q == ST_RUN_B) flag_b_q <= 1'b1;
                else                     flag_a_q <= 1'b1;
            end
            if (running) run_b_q <= (state_q == ST_RUN_B);
        end
    end

    // Counting continues only while staying in the same run state; any entry restarts the second.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else if (running && (state_d == state_q)) begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
        end else begin
            presc_q <= '0;
        end
    end

    always_comb begin
        bus.active_a = (state_q == ST_RUN_A);
        bus.active_b = (state_q == ST_RUN_B);
        bus.flag_a   = flag_a_q;
        bus.flag_b   = flag_b_q;
        unique case (state_q)
            ST_RUN_A:  bus.disp_b = 1'b0;
            ST_RUN_B:  bus.disp_b = 1'b1;
            ST_PAUSED: bus.disp_b = run_b_q;
            ST_FLAG:   bus.disp_b = flag_b_q;
            default:   bus.disp_b = 1'b0;
        endcase
        disp_time  = bus.disp_b ? time_b_q : time_a_q;
        bus.digit3 = disp_time.min_tens;
        bus.digit2 = disp_time.min_ones;
        bus.digit1 = disp_time.sec_tens;
        bus.digit0 = disp_time.sec_ones;
    end

endmodule

// File: tb/tb_chess_clock_timer.sv
// Bench for chess_clock_timer with TICK_DIV=4, START_MIN=1: directed scenarios
// plus a randomized run checked against a seconds-based reference model.
module tb_chess_clock_timer;

    localparam int TDIV = 4;
    localparam int SMIN = 1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    chess_clock_timer_if bus ();

    chess_clock_timer #(.TICK_DIV(TDIV), .START_MIN(SMIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: times kept as plain seconds, state as small integers
    // (0 idle, 1 A running, 2 B running, 3 paused, 4 flagged).
    int m_st;
    int m_ta;
    int m_tb;
    int m_cnt;
    bit m_runb;
    bit m_fa;
    bit m_fb;

    task automatic model_reset();
        m_st   = 0;
        m_ta   = SMIN * 60;
        m_tb   = SMIN * 60;
        m_cnt  = 0;
        m_runb = 1'b0;
        m_fa   = 1'b0;
        m_fb   = 1'b0;
    endtask

    task automatic model_edge(input bit s, input bit pa, input bit pb, input bit pz);
        int cur;
        bit tk;
        if (s) begin
            if (m_st != 0) model_reset();
            else begin
                m_st  = 1;
                m_cnt = 0;
            end
            return;
        end
        case (m_st)
            1, 2: begin
                tk    = (m_cnt == TDIV - 1);
                m_cnt = tk ? 0 : m_cnt + 1;
                if (tk) begin
                    if (m_st == 1 && m_ta > 0) m_ta--;
                    if (m_st == 2 && m_tb > 0) m_tb--;
                    cur = (m_st == 1) ? m_ta : m_tb;
                    if (cur == 0) begin
                        if (m_st == 1) m_fa = 1'b1;
                        else           m_fb = 1'b1;
                        m_st = 4;
                        return;
                    end
                end
                m_runb = (m_st == 2);
                if (pz) m_st = 3;
                else if (m_st == 1 && pa) begin m_st = 2; m_cnt = 0; end
                else if (m_st == 2 && pb) begin m_st = 1; m_cnt = 0; end
            end
            3: begin
                if (pz) begin
                    m_st  = m_runb ? 2 : 1;
                    m_cnt = 0;
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [20:0] model_out();
        int sec;
        bit db;
        case (m_st)
            2:       db = 1'b1;
            3:       db = m_runb;
            4:       db = m_fb;
            default: db = 1'b0;
        endcase
        sec = db ? m_tb : m_ta;
        return {4'((sec / 60) / 10), 4'((sec / 60) % 10), 4'((sec % 60) / 10), 4'((sec % 60) % 10),
                db, (m_st == 1), (m_st == 2), m_fa, m_fb};
    endfunction

    function automatic logic [20:0] exp_vec(input int d3, input int d2, input int d1, input int d0,
                                            input bit db, input bit aa, input bit ab,
                                            input bit fa, input bit fb);
        return {4'(d3), 4'(d2), 4'(d1), 4'(d0), db, aa, ab, fa, fb};
    endfunction

    function automatic logic [20:0] obs();
        return {bus.digit3, bus.digit2, bus.digit1, bus.digit0,
                bus.disp_b, bus.active_a, bus.active_b, bus.flag_a, bus.flag_b};
    endfunction

    task automatic step(input bit s, input bit pa, input bit pb, input bit pz);
        @(negedge clk);
        bus.start   = s;
        bus.press_a = pa;
        bus.press_b = pb;
        bus.pause   = pz;
        @(posedge clk);
        model_edge(s, pa, pb, pz);
        #1;
        bus.start   = 1'b0;
        bus.press_a = 1'b0;
        bus.press_b = 1'b0;
        bus.pause   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        logic [20:0] e;
        repeat (2) @(posedge clk);
        #1;
        e = exp_vec(0, 1, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL reset_state: got %h want %h", obs(), e); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL idle_hold: got %h want %h", obs(), e); end
    endtask

    task automatic test_start_countdown();
        logic [20:0] e;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        e = exp_vec(0, 1, 0, 0, 0, 1, 0, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL start_entry: got %h want %h", obs(), e); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL before_first_tick: got %h want %h", obs(), e); end
        idle(1);
        e = exp_vec(0, 0, 5, 9, 0, 1, 0, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL first_tick: got %h want %h", obs(), e); end
        idle(4);
        e = exp_vec(0, 0, 5, 8, 0, 1, 0, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL second_tick: got %h want %h", obs(), e); end
    endtask

    task automatic test_press_on_tick();
        logic [20:0] e;
        idle(3);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        e = exp_vec(0, 1, 0, 0, 1, 0, 1, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL press_on_tick: got %h want %h", obs(), e); end
        n_checks++;
        if (m_ta !== 57) begin n_fail++; $display("FAIL model_a_57: got %0d want 57", m_ta); end
    endtask

    task automatic test_pause_resume();
        logic [20:0] e;
        idle(2);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        e = exp_vec(0, 1, 0, 0, 1, 0, 0, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL paused_entry: got %h want %h", obs(), e); end
        for (int i = 0; i < 20; i++) step(1'b0, i[0], ~i[0], 1'b0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL paused_hold: got %h want %h", obs(), e); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        e = exp_vec(0, 1, 0, 0, 1, 0, 1, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL resume_no_early_tick: got %h want %h", obs(), e); end
        idle(1);
        e = exp_vec(0, 0, 5, 9, 1, 0, 1, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL resume_tick: got %h want %h", obs(), e); end
    endtask

    task automatic test_flag();
        logic [20:0] e;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        e = exp_vec(0, 1, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL reload_idle: got %h want %h", obs(), e); end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(60 * TDIV - 1);
        e = exp_vec(0, 0, 0, 1, 0, 1, 0, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL last_second: got %h want %h", obs(), e); end
        idle(1);
        e = exp_vec(0, 0, 0, 0, 0, 0, 0, 1, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL flag_a_set: got %h want %h", obs(), e); end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        idle(TDIV);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL flag_ignores: got %h want %h", obs(), e); end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        e = exp_vec(0, 1, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL flag_restart: got %h want %h", obs(), e); end
    endtask

    task automatic test_async_reset();
        logic [20:0] e;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(29 * TDIV);
        e = exp_vec(0, 0, 3, 1, 1, 0, 1, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL b_at_31: got %h want %h", obs(), e); end
        #2;
        rst = 1'b1;
        #1;
        e = exp_vec(0, 1, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL async_reset: got %h want %h", obs(), e); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(TDIV);
        e = exp_vec(0, 0, 5, 9, 0, 1, 0, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL after_reset_run: got %h want %h", obs(), e); end
    endtask

    task automatic test_random();
        bit s, pa, pb, pz;
        int errs;
        errs = 0;
        for (int i = 0; i < 1500; i++) begin
            s  = ($urandom_range(0, 299) == 0);
            pa = ($urandom_range(0, 24) == 0);
            pb = ($urandom_range(0, 24) == 0);
            pz = ($urandom_range(0, 49) == 0);
            step(s, pa, pb, pz);
            n_checks++;
            if (obs() !== model_out()) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cycle_%0d: got %h want %h", i, obs(), model_out());
            end
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.press_a = 1'b0;
        bus.press_b = 1'b0;
        bus.pause   = 1'b0;
        model_reset();
        test_reset();
        test_start_countdown();
        test_press_on_tick();
        test_pause_resume();
        test_flag();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chess_clock_timer.md
# chess_clock_timer

Two-player chess clock core. It counts down each player's remaining time in BCD minutes:seconds and handles move hand-over, pause/resume and flag (time-out) detection. It sits directly upstream of the four 7-segment digit decoders: it drives their 4-bit digit inputs with the displayed player's MM:SS, plus status lamps.

## Interface
- TICK_DIV, default 50_000_000: clock cycles per one-second tick. Minimum 2.
- START_MIN, default 5: initial minutes per player. Range 1..99.
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse: start game / reload
- press_a  in  1  single-cycle pulse, player A ends move (debounced upstream)
- press_b  in  1  single-cycle pulse, player B ends move
- pause  in  1  single-cycle pulse, toggle pause
- digit3  out  4  minutes tens (BCD) of displayed player
- digit2  out  4  minutes ones
- digit1  out  4  seconds tens (0..5)
- digit0  out  4  seconds ones
- disp_b  out  1  0 = A displayed, 1 = B displayed
- active_a, active_b  out  1 each  clock of that player running
- flag_a, flag_b  out  1 each  that player's time reached 00:00

## Operation
- States: IDLE, RUN_A, RUN_B, PAUSED, FLAG. A registered run_b bit records whose clock was last running.
- IDLE: both times hold START_MIN:00. start -> RUN_A.
- RUN_A: tick decrements A. press_a -> RUN_B. pause -> PAUSED with run_b=0. press_b is ignored.
- RUN_B: symmetric to RUN_A. press_b -> RUN_A. pause -> PAUSED with run_b=1.
- PAUSED: pause -> RUN_A or RUN_B per run_b. Presses are ignored.
- FLAG: all inputs ignored except start.
- start in any non-IDLE state: reload both times to START_MIN:00, clear flags, go to IDLE. start has priority over every other input.
- Priority within a run state: start > pause > press of active player. A tick in the same cycle is applied before the transition.
- Decrement of a nonzero time produces the borrow chain below.
  - Seconds ones: 0 -> 9 with borrow.
  - Seconds tens: 0 -> 5 with borrow.
  - Minutes ones: 0 -> 9 with borrow.
  - Minutes tens: decrements.
- 00:00 is never decremented.
- If a decrement yields 00:00:
  - Next state is FLAG. This overrides a same-cycle press or pause.
  - The running player's flag_x is set.
- Display selection:
  - IDLE: disp_b=0.
  - RUN_A / RUN_B: that player.
  - PAUSED: run_b.
  - FLAG: the flagged player.
- active_a = (state==RUN_A). active_b = (state==RUN_B).

## Timing
- Prescaler counts 0..TICK_DIV-1 only in RUN_A/RUN_B. tick = (prescaler==TICK_DIV-1) in a run state.
- Prescaler clears to 0 on every entry into RUN_A/RUN_B, including a player switch and a resume. It holds 0 elsewhere.
- The first decrement of a move lands on the TICK_DIV-th rising edge after entry. The new value is visible in the following cycle.
- Outputs are combinational decodes of registered state and times. Zero added latency: a state change on edge N is visible after edge N.
- Input pulses are sampled on the edge and take effect that edge. Pulses longer than one cycle re-trigger each cycle.
- Reset values:
  - state=IDLE, run_b=0, prescaler=0.
  - Both times START_MIN:00.
  - digit3=START_MIN/10, digit2=START_MIN%10, digit1=0, digit0=0.
  - disp_b=0, active_a=active_b=0, flag_a=flag_b=0.
- rst asserted mid-run forces the reset values immediately, without waiting for clk.

## Structure
- Package chess_clock_pkg:
  - state enum.
  - bcd_t (4-bit) typedef.
  - mmss_t struct (four bcd_t).
  - function building the START_MIN:00 reload value.
- Sub-module bcd_mmss_dec: combinational mmss_t in -> decremented mmss_t out plus is_zero_next and is_zero flags. Instantiated once, fed by the active player's time via mux.
- Top holds the FSM, the prescaler and two mmss_t registers.

## Test plan
All scenarios use TICK_DIV=4, START_MIN=1.
- Reset -> digits 0,1,0,0; all status outputs 0; state IDLE.
- Pulse start, then wait 4 cycles -> active_a=1, display 0,0,5,9. After 4 more cycles -> 0,0,5,8.
- In RUN_A at 00:58, pulse press_a on the same edge as a tick.
  - Required: A becomes 00:57, state RUN_B, disp_b=1, display 0,1,0,0.
  - press_b pulsed during RUN_A earlier has no effect.
- In RUN_B at 3 cycles into a second, pulse pause, wait 20 cycles, then pulse pause again.
  - Required: time unchanged while PAUSED.
  - The next decrement comes exactly 4 cycles after resume, because the prescaler was cleared.
- Let A run 60 ticks from 01:00.
  - Required: reaches 0,0,0,0; state FLAG; flag_a=1; active_a=0.
  - press_a and pause are then ignored. start -> IDLE, both 01:00, flag_a=0.
- Assert rst asynchronously between edges while in RUN_B at 00:31.
  - Required: outputs go to reset values before the next clk edge.
  - Deassert rst, then pulse start -> A counts from 01:00.
